// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shift-add multiplier.
//   mult_state_e : sequencer states (idle / iterating / product ready)
//   MULT_WIDTH   : operand width, fixed by the 32-bit partial-product array
//   MULT_CNT_W   : iteration counter width
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/and_gate_32bit.sv
// and_gate_32bit: 32-bit bitwise AND, used as the partial-product generator.
//   a, b : 32-bit operands
//   y    : a & b
module and_gate_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a & b;

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle unsigned shift-add multiplier controller.
// One AND array plus one 33-bit adder are reused over WIDTH iterations;
// the 64-bit product is shifted right through {product_hi, product_lo}.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request a multiply (honoured only in IDLE or DONE)
//   multiplicand : operand A, latched on accepted start
//   multiplier   : operand B, loaded into product_lo on accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse, product final
//   product_hi/lo: upper / lower product words
module mult_sequencer
    import mult_pkg::*;
#(
    // Only 32 is supported: the partial-product array is fixed-width.
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    mult_state_e           state_q, state_d;
    logic [MULT_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;

    logic [WIDTH-1:0]      pp;
    logic [WIDTH:0]        sum;

    // Partial product: M gated by the current multiplier LSB.
    and_gate_32bit u_pp (
        .a (m_q),
        .b ({WIDTH{lo_q[0]}}),
        .y (pp)
    );

    assign sum = {1'b0, hi_q} + {1'b0, pp};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MS_IDLE, MS_DONE: begin
                if (start) begin
                    m_d     = multiplicand;
                    hi_d    = '0;
                    lo_d    = multiplier;
                    cnt_d   = '0;
                    state_d = MS_RUN;
                end else if (state_q == MS_DONE) begin
                    state_d = MS_IDLE;
                end
            end
            MS_RUN: begin
                // {S, lo} >> 1: carry lands in hi[31], S[0] in lo[31].
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                // Counter wraps to 0 naturally on the final iteration.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MULT_CNT_W'(WIDTH - 1)) begin
                    state_d = MS_DONE;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy       = (state_q == MS_RUN);
    assign done       = (state_q == MS_DONE);
    assign product_hi = hi_q;
    assign product_lo = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int tests = 0;
    int fails = 0;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit unsigned product.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Drive start for one edge; afterwards we are in cycle 1 of RUN.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Walk forward from cycle cyc_in until done (bounded); returns done cycle and busy cycles seen.
    task automatic wait_done(input int cyc_in, output int cyc, output int nbusy);
        cyc   = cyc_in;
        nbusy = cyc_in - 1;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            step();
            cyc++;
        end
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cyc, nb;
        launch(a, b);
        wait_done(1, cyc, nb);
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
        chk({tag, "_product"}, {product_hi, product_lo}, model(a, b));
        step();
        chk({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_hold"}, {product_hi, product_lo}, model(a, b));
    endtask

    initial begin
        int cyc, nb, ndone;
        logic [31:0] ra, rb;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        chk("reset_state", {30'd0, busy, done, product_hi, product_lo}, 64'd0);
        reset = 1'b0;
        step();
        chk("idle_stays", {62'd0, busy, done}, 64'd0);

        full_op("3x5", 32'd3, 32'd5);
        chk("3x5_const", {product_hi, product_lo}, 64'h0000_0000_0000_000F);
        full_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ffxff_const", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
        full_op("msbx2", 32'h8000_0000, 32'd2);
        chk("msbx2_const", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
        full_op("zero", 32'd0, 32'h1234_5678);
        chk("zero_const", {product_hi, product_lo}, 64'd0);

        // start during RUN is ignored
        launch(32'd3, 32'd5);
        repeat (9) step();                         // now in cycle 10
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
        start        = 1'b1;
        step();
        start        = 1'b0;
        wait_done(11, cyc, nb);
        chk("midstart_latency", 64'(cyc), 64'd33);
        chk("midstart_product", {product_hi, product_lo}, 64'd15);
        step();

        // reset mid-RUN aborts without a done pulse
        launch(32'h0001_0001, 32'h0000_FFFF);
        repeat (14) step();                        // now in cycle 15
        chk("pre_abort_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_state", {30'd0, busy, done, product_hi, product_lo}, 64'd0);
        ndone = 0;
        repeat (40) begin
            step();
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // back-to-back: start held in DONE cycle
        launch(32'd3, 32'd5);
        wait_done(1, cyc, nb);
        chk("b2b_first_latency", 64'(cyc), 64'd33);
        chk("b2b_first_product", {product_hi, product_lo}, 64'd15);
        launch(32'd7, 32'd9);
        chk("b2b_no_gap", {62'd0, busy, done}, 64'd2);
        wait_done(1, cyc, nb);
        chk("b2b_second_latency", 64'(cyc), 64'd33);
        chk("b2b_second_product", {product_hi, product_lo}, 64'h3F);
        step();

        // randomized operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i == 0) ra = 32'd1;
            if (i == 1) rb = 32'hFFFF_FFFF;
            full_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
